// File: rtl/bcd_pkg.sv
// Shared widths and active-low seven-segment patterns for the BCD display block.
// Segment bit order is g..a (bit 6 = g, bit 0 = a).
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic digit_invalid(input logic [BCD_W-1:0] d);
        return d > BCD_W'(9);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// One BCD digit to active-low segments; invalid digits show "E", or blank
// while blank_err_i is high.
module bcd_seg_decode
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    input  logic             blank_err_i,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = blank_err_i ? SEG_BLANK : SEG_E;
        case (digit_i)
            4'd0:    seg_c = SEG_DIGIT[0];
            4'd1:    seg_c = SEG_DIGIT[1];
            4'd2:    seg_c = SEG_DIGIT[2];
            4'd3:    seg_c = SEG_DIGIT[3];
            4'd4:    seg_c = SEG_DIGIT[4];
            4'd5:    seg_c = SEG_DIGIT[5];
            4'd6:    seg_c = SEG_DIGIT[6];
            4'd7:    seg_c = SEG_DIGIT[7];
            4'd8:    seg_c = SEG_DIGIT[8];
            4'd9:    seg_c = SEG_DIGIT[9];
            default: ;
        endcase
    end

endmodule

// File: rtl/bcd_display_n.sv
// N-digit BCD value register with load/increment, sticky invalid-digit flags
// and registered seven-segment outputs. Define BCD_BLINK_EN to blink invalid digits.
module bcd_display_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [BCD_W*DIGITS-1:0]   din,
    input  logic                      inc,
    input  logic                      clr_err,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic [SEG_W*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]         err,
    output logic                      carry_out
);

    localparam int unsigned VAL_W = BCD_W * DIGITS;
    localparam int unsigned HEX_W = SEG_W * DIGITS;

    if (DIGITS == 0 || DIGITS > 8 || BLINK_DIV < 2) begin : g_param_err
        $error("bcd_display_n: illegal DIGITS or BLINK_DIV");
    end

    logic [VAL_W-1:0] value_q, value_d;
    logic [DIGITS-1:0] err_q, err_d;
    logic             carry_q, carry_d;
    logic [HEX_W-1:0] hex_q;
    logic [HEX_W-1:0] seg_c;
    logic [VAL_W-1:0] inc_val;
    logic             all_valid;
    logic             ripple;
    logic [BCD_W-1:0] nib;
    logic             blank_err;

    // Next value / error / carry; load has priority over inc, set over clear.
    always_comb begin
        value_d   = value_q;
        err_d     = err_q;
        carry_d   = 1'b0;
        all_valid = 1'b1;
        ripple    = 1'b1;
        inc_val   = '0;
        nib       = '0;

        for (int i = 0; i < DIGITS; i++) begin
            nib = value_q[BCD_W*i +: BCD_W];
            if (digit_invalid(nib)) begin
                all_valid = 1'b0;
            end
            if (ripple) begin
                if (nib == BCD_W'(9)) begin
                    nib = '0;
                end else begin
                    nib    = nib + BCD_W'(1);
                    ripple = 1'b0;
                end
            end
            inc_val[BCD_W*i +: BCD_W] = nib;
        end

        if (clr_err) begin
            err_d = '0;
        end

        if (load) begin
            value_d = din;
            for (int i = 0; i < DIGITS; i++) begin
                if (digit_invalid(din[BCD_W*i +: BCD_W])) begin
                    err_d[i] = 1'b1;
                end
            end
        end else if (inc && all_valid) begin
            value_d = inc_val;
            carry_d = ripple;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            err_q   <= '0;
            carry_q <= 1'b0;
            hex_q   <= {DIGITS{SEG_DIGIT[0]}};
        end else begin
            value_q <= value_d;
            err_q   <= err_d;
            carry_q <= carry_d;
            hex_q   <= seg_c;
        end
    end

`ifdef BCD_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Free-running half-period counter; phase high means invalid digits show "E".
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blank_err = ~phase_q;
`else
    assign blank_err = 1'b0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_seg_decode u_dec (
            .digit_i     (value_q[BCD_W*g +: BCD_W]),
            .blank_err_i (blank_err),
            .seg_c       (seg_c[SEG_W*g +: SEG_W])
        );
    end

    assign value     = value_q;
    assign err       = err_q;
    assign carry_out = carry_q;
    assign hex       = hex_q;

endmodule

// File: tb/tb_bcd_display_n.sv
// Self-checking bench for bcd_display_n: directed scenarios plus random
// strobes compared against a decimal-arithmetic reference model.
module tb_bcd_display_n;

    localparam int unsigned DIGITS    = 2;
    localparam int unsigned BLINK_DIV = 4;
    localparam int unsigned VW        = 4 * DIGITS;
    localparam int unsigned HW        = 7 * DIGITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic          inc = 1'b0;
    logic          clr_err = 1'b0;
    logic [VW-1:0] din = '0;
    logic [VW-1:0] value;
    logic [HW-1:0] hex;
    logic [DIGITS-1:0] err;
    logic          carry_out;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [VW-1:0]     m_val;
    logic [DIGITS-1:0] m_err;
    logic              m_carry;
    logic [HW-1:0]     m_hex;
    int                m_cnt;
    logic              m_phase;

    bcd_display_n #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (din),
        .inc       (inc),
        .clr_err   (clr_err),
        .value     (value),
        .hex       (hex),
        .err       (err),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    function automatic bit all_valid(input logic [VW-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_int(input logic [VW-1:0] v);
        int n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [VW-1:0] to_bcd(input int n);
        logic [VW-1:0] r = '0;
        int k = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return r;
    endfunction

    function automatic logic [HW-1:0] show(input logic [VW-1:0] v, input logic phase);
        logic [HW-1:0] r = '0;
        logic [3:0] d;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (d <= 4'd9) r[7*i +: 7] = seg_tab[d];
            else           r[7*i +: 7] = phase ? 7'b0000110 : 7'b1111111;
        end
        return r;
    endfunction

    function automatic int full_scale();
        int n = 1;
        for (int i = 0; i < DIGITS; i++) n = n * 10;
        return n;
    endfunction

    task automatic model_reset();
        m_val   = '0;
        m_err   = '0;
        m_carry = 1'b0;
        m_hex   = show('0, 1'b1);
        m_cnt   = 0;
        m_phase = 1'b1;
    endtask

    // One rising edge of the reference; display follows the pre-edge value and phase.
    task automatic model_edge(input logic ld, input logic [VW-1:0] d, input logic in, input logic clr);
        logic [VW-1:0] old_val = m_val;
        logic old_phase = m_phase;
        int n;
        m_carry = 1'b0;
        if (clr) m_err = '0;
        if (ld) begin
            m_val = d;
            for (int i = 0; i < DIGITS; i++)
                if (d[4*i +: 4] > 4'd9) m_err[i] = 1'b1;
        end else if (in && all_valid(old_val)) begin
            n = to_int(old_val) + 1;
            if (n == full_scale()) begin
                n = 0;
                m_carry = 1'b1;
            end
            m_val = to_bcd(n);
        end
        m_hex = show(old_val, old_phase);
`ifdef BCD_BLINK_EN
        if (m_cnt == int'(BLINK_DIV) - 1) begin
            m_cnt = 0;
            m_phase = ~m_phase;
        end else begin
            m_cnt++;
        end
`endif
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".value"}, 64'(value), 64'(m_val));
        chk({tag, ".err"},   64'(err),   64'(m_err));
        chk({tag, ".carry"}, 64'(carry_out), 64'(m_carry));
        chk({tag, ".hex"},   64'(hex),   64'(m_hex));
    endtask

    task automatic step(input logic ld, input logic [VW-1:0] d, input logic in,
                        input logic clr, input string tag);
        @(negedge clk);
        load = ld; din = d; inc = in; clr_err = clr;
        @(posedge clk);
        model_edge(ld, d, in, clr);
        #1;
        check_all(tag);
    endtask

    // Reset asserted mid-cycle with strobes pending; they must be forgotten.
    task automatic do_reset(input string tag);
        @(negedge clk);
        load = 1'b1; din = 8'h55; inc = 1'b1; clr_err = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all(tag);
        @(negedge clk);
        load = 1'b0; inc = 1'b0; clr_err = 1'b0; din = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [VW-1:0] d;
        logic ld, in, clr;

        do_reset("reset");
        step(0, 8'h00, 0, 0, "idle_after_reset");

        step(1, 8'h42, 0, 0, "load42");
        step(0, 8'h00, 0, 0, "load42_hex");
        chk("load42_hex0", 64'(hex[6:0]), 64'(7'b0100100));

        step(1, 8'h99, 0, 0, "load99");
        step(0, 8'h00, 1, 0, "wrap");
        chk("wrap_carry", 64'(carry_out), 64'(1'b1));
        step(0, 8'h00, 0, 0, "wrap_after");
        chk("wrap_carry_low", 64'(carry_out), 64'(1'b0));

        step(1, 8'h3C, 0, 0, "load3C");
        chk("load3C_err", 64'(err), 64'(2'b01));
        step(0, 8'h00, 1, 0, "inc_blocked");
        chk("inc_blocked_val", 64'(value), 64'(8'h3C));
        step(0, 8'h00, 0, 1, "clr_err");
        chk("clr_err_err", 64'(err), 64'(2'b00));
        for (int k = 0; k < 12; k++) step(0, 8'h00, 0, 0, "blink_idle");
`ifndef BCD_BLINK_EN
        chk("steady_E", 64'(hex[6:0]), 64'(7'b0000110));
`endif

        step(1, 8'hA5, 0, 1, "set_beats_clear");
        chk("set_beats_clear_err", 64'(err), 64'(2'b10));

        step(1, 8'h19, 1, 0, "load_beats_inc");
        chk("load_beats_inc_val", 64'(value), 64'(8'h19));
        step(0, 8'h00, 1, 0, "inc19");
        chk("inc19_val", 64'(value), 64'(8'h20));

        step(1, 8'hF7, 0, 0, "loadF7");
        do_reset("mid_reset");
        step(0, 8'h00, 0, 0, "post_reset_idle");
        step(0, 8'h00, 1, 0, "post_reset_inc");

        for (int k = 0; k < 400; k++) begin
            ld  = ($urandom_range(0, 3) == 0);
            in  = ($urandom_range(0, 1) == 0);
            clr = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < DIGITS; i++)
                d[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) d = {DIGITS{4'h9}};
            step(ld, d, in, clr, "random");
            if (k == 200) do_reset("random_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_n.md
BCD_DISPLAY_N -- requirements
Module: bcd_display_n

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD digits/displays, legal 1..8.
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, legal >= 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 load  input  1  one-cycle strobe; capture din into value register.
REQ-006 din  input  4*DIGITS  candidate BCD value; digit i = din[4i+3:4i].
REQ-007 inc  input  1  one-cycle strobe; BCD-increment stored value.
REQ-008 clr_err  input  1  one-cycle strobe; clear sticky error flags.
REQ-009 value  output  4*DIGITS  stored value register.
REQ-010 hex  output  7*DIGITS  active-low segments; display i = hex[7i+6:7i], bit 0 = seg a ... bit 6 = seg g.
REQ-011 err  output  DIGITS  sticky per-digit invalid-digit flags.
REQ-012 carry_out  output  1  one-cycle pulse on full wrap.

Function
REQ-013 Digit i is invalid when its stored nibble > 9; invalid nibbles are stored unchanged.
REQ-014 load=1: value <= din next edge; err[i] <= 1 for each invalid din digit, others keep state.
REQ-015 inc=1 with load=0 and all stored digits valid: value += 1 in BCD, digit 9 -> 0 with ripple carry into next digit.
REQ-016 inc with all digits 9: value -> 0, carry_out=1 for exactly that one cycle; carry_out=0 otherwise.
REQ-017 inc while any stored digit invalid: ignored, value and carry_out unchanged.
REQ-018 load and inc same cycle: load wins, inc discarded.
REQ-019 clr_err and load with invalid digit same cycle: err bit for that digit ends 1 (set wins); other bits clear.
REQ-020 hex registered: reflects value one cycle after value changes.
REQ-021 Valid digit d: standard pattern (0 = 7'b1000000 ... 9 = 7'b0010000, bit 6..0 order g..a).
REQ-022 Invalid digit: "E" pattern 7'b0000110, subject to REQ-027.
REQ-023 Blink counter: free-running 0..BLINK_DIV-1, wraps to 0 and toggles blink phase on wrap.

Reset
REQ-024 rst_n low: value = 0, err = 0, carry_out = 0, blink counter = 0, blink phase = on, hex = all displays 7'b1000000, immediately, independent of clk.
REQ-025 Reset asserted mid-operation aborts any pending load/inc; no strobe is remembered across reset.
REQ-026 First edge after rst_n rises processes inputs normally.

Configuration
REQ-027 Macro BCD_BLINK_EN defined: invalid digits alternate "E" (phase on) and blank 7'b1111111 (phase off); undefined: invalid digits show steady "E", blink counter absent, BLINK_DIV unused.

Structure
REQ-028 Package bcd_pkg: segment constants SEG_DIGIT[0..9], SEG_E, SEG_BLANK, localparam BCD_W = 4, SEG_W = 7.
REQ-029 One sub-module bcd_seg_decode: 4-bit digit + blank/error controls -> 7-bit active-low segments, combinational, instantiated DIGITS times.

Verification
REQ-030 Reset then load din=8'h42 -> value=8'h42, err=2'b00, hex[6:0]=7'b0100100 one cycle after value.
REQ-031 load 8'h99, inc -> value=8'h00, carry_out=1 one cycle, then 0.
REQ-032 load 8'h3C -> err=2'b01; inc -> value stays 8'h3C; clr_err -> err=2'b00, hex[6:0] still "E".
REQ-033 load 8'h19 and inc same cycle -> value=8'h19; next inc -> 8'h20.
REQ-034 BCD_BLINK_EN, BLINK_DIV=4, invalid digit 0 -> hex[6:0] alternates 7'b0000110/7'b1111111 every 4 cycles; without macro steady 7'b0000110.
REQ-035 rst_n low mid-stream after load 8'hF7 -> value=0, err=0, carry_out=0 asynchronously.
